// File: rtl/wb_frame_pkg.sv
// Shared types and Wishbone cycle-type codes for the frame reader.
package wb_frame_pkg;

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef struct packed {
        logic        sof;
        logic [31:0] data;
    } pix_word_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle carrying its own clock and synchronous reset.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_ms;
    logic        ack;
    logic [31:0] dat_sm;

    modport master (
        input  clk, rst, ack, dat_sm,
        output cyc, stb, we, adr, sel, cti, bte, dat_ms
    );

    modport slave (
        input  clk, rst, cyc, stb, we, adr, sel, cti, bte, dat_ms,
        output ack, dat_sm
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO with occupancy count.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign empty = (count == '0);
    // Head reads as zero while empty so the stream outputs idle cleanly.
    assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/wb_frame_reader.sv
// Wishbone burst reader sweeping a frame buffer into a valid/ready stream.
module wb_frame_reader
    import wb_frame_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int          FRAME_WORDS = 1024,
    parameter int          BURST_LEN   = 8,
    parameter int          FIFO_DEPTH  = 32
) (
    wshb_if.master      wb_m,
    input  logic        enable,
    output logic [31:0] pix_data,
    output logic        pix_sof,
    output logic        pix_valid,
    input  logic        pix_ready
);
    localparam int IW = $clog2(FRAME_WORDS) + 1;
    localparam int BW = $clog2(BURST_LEN);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic [2:0]    cti_q, cti_d;
    logic [31:0]   adr_q, adr_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [IW-1:0] idx_q, idx_d;

    logic          push, pop, empty, room, last;
    logic [CW-1:0] count, occ;
    logic [IW-1:0] idx_inc;
    pix_word_t     din, head;

    assign pop  = pix_valid & pix_ready;
    assign push = (state_q == BURST) & wb_m.ack;
    assign last = push & (cti_q == CTI_END);

    // Admission looks at occupancy after this cycle's pop.
    assign occ  = count - CW'(pop);
    assign room = int'(occ) <= (FIFO_DEPTH - BURST_LEN);

    assign idx_inc = idx_q + IW'(BURST_LEN);

    assign din.sof  = (idx_q == '0) && (beat_q == '0);
    assign din.data = wb_m.dat_sm;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        cti_d   = cti_q;
        adr_d   = adr_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (enable && room) begin
                    state_d = BURST;
                    cyc_d   = 1'b1;
                    cti_d   = CTI_INCR;
                    adr_d   = BASE_ADR + (32'(idx_q) << 2);
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (push) begin
                    adr_d  = adr_q + 32'd4;
                    beat_d = beat_q + BW'(1);
                    cti_d  = (beat_q == BW'(BURST_LEN - 2)) ?
                             CTI_END : CTI_INCR;
                end
                if (last) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    cti_d   = CTI_CLASSIC;
                    beat_d  = '0;
                    idx_d   = (idx_inc == IW'(FRAME_WORDS)) ? '0 : idx_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_m.clk) begin
        if (wb_m.rst) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            cti_q   <= CTI_CLASSIC;
            adr_q   <= BASE_ADR;
            beat_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            cti_q   <= cti_d;
            adr_q   <= adr_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(pix_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_m.clk),
        .rst   (wb_m.rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .count (count)
    );

    assign wb_m.cyc    = cyc_q;
    assign wb_m.stb    = cyc_q;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'hF;
    assign wb_m.bte    = 2'b00;
    assign wb_m.cti    = cti_q;
    assign wb_m.adr    = adr_q;
    assign wb_m.dat_ms = '0;

    assign pix_data  = head.data;
    assign pix_sof   = head.sof;
    assign pix_valid = ~empty;

endmodule

// File: tb/tb_wb_frame_reader.sv
// Bench for wb_frame_reader with a burst-capable registered-ack BRAM model.
module tb_wb_frame_reader;
    import wb_frame_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int FW = 32;
    localparam int BL = 8;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        pix_ready = 1'b0;
    logic [31:0] pix_data;
    logic        pix_sof;
    logic        pix_valid;

    wshb_if wb (.clk(clk), .rst(rst));

    wb_frame_reader #(
        .BASE_ADR    (BASE),
        .FRAME_WORDS (FW),
        .BURST_LEN   (BL),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .wb_m      (wb),
        .enable    (enable),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] bram [64];
    logic [31:0] rd_adr;

    initial begin
        for (int i = 0; i < 64; i++) bram[i] = 32'hA000_0000 + i;
    end

    assign rd_adr = (wb.ack && wb.cti == CTI_INCR) ? wb.adr + 32'd4 : wb.adr;

    always @(posedge clk) begin
        if (rst) begin
            wb.ack    <= 1'b0;
            wb.dat_sm <= '0;
        end else begin
            wb.ack    <= wb.cyc && wb.stb && !(wb.ack && wb.cti == CTI_END);
            wb.dat_sm <= bram[rd_adr[7:2]];
        end
    end

    logic [32:0] expq[$];
    logic [32:0] want;
    int m_idx = 0;
    int beat = 0;
    int bursts = 0;
    int pops = 0;
    int sofs = 0;
    int run = 0;
    int gap = 0;
    bit have_prev = 0;
    bit prev_cyc = 0;
    bit b2b = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            expq.delete();
            m_idx = 0;
            beat = 0;
            run = 0;
            gap = 0;
            have_prev = 0;
            prev_cyc = 0;
        end else begin
            if (wb.ack && wb.cyc) begin
                chk("adr", wb.adr, BASE + 32'(4 * m_idx));
                chk("cti", wb.cti, (beat == BL - 1) ? CTI_END : CTI_INCR);
                expq.push_back({m_idx == 0, 32'hA000_0000 + 32'(m_idx)});
                m_idx++;
                beat++;
                if (beat == BL) begin
                    beat = 0;
                    bursts++;
                    if (m_idx == FW) m_idx = 0;
                end
            end
            if (wb.cyc) begin
                if (!prev_cyc) begin
                    chk("we_sel_bte", {wb.we, wb.sel, wb.bte, wb.stb},
                        {1'b0, 4'hF, 2'b00, 1'b1});
                    if (b2b && have_prev) chk("gap", gap, 1);
                end
                run++;
            end else begin
                if (prev_cyc) begin
                    chk("cyc_len", run, BL + 1);
                    run = 0;
                    gap = 0;
                    have_prev = 1;
                end
                gap++;
            end
            prev_cyc = wb.cyc;
            if (pix_valid && pix_ready) begin
                pops++;
                if (pix_sof) sofs++;
                if (expq.size() == 0) begin
                    chk("pix_extra", 0, 1);
                end else begin
                    want = expq.pop_front();
                    chk("pix_word", {pix_sof, pix_data}, want);
                end
            end
        end
    end

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (pops < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("pop_wait", pops >= target, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        bit ok = 0;
        while (!ok && n < budget) begin
            @(posedge clk);
            #1;
            ok = !wb.cyc && !pix_valid;
            n++;
        end
        chk("idle_wait", ok, 1);
    endtask

    task automatic wait_rise(input int budget);
        int n = 0;
        bit p = wb.cyc;
        bit ok = 0;
        while (!ok && n < budget) begin
            @(posedge clk);
            #1;
            ok = wb.cyc && !p;
            p = wb.cyc;
            n++;
        end
        chk("rise_wait", ok, 1);
    endtask

    int b0;
    logic [31:0] resume_adr;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", wb.cyc, 0);
        chk("rst_stb", wb.stb, 0);
        chk("rst_we", wb.we, 0);
        chk("rst_cti", wb.cti, CTI_CLASSIC);
        chk("rst_bte", wb.bte, 0);
        chk("rst_sel", wb.sel, 4'hF);
        chk("rst_adr", wb.adr, BASE);
        chk("rst_valid", pix_valid, 0);
        chk("rst_sof", pix_sof, 0);
        chk("rst_data", pix_data, 0);
        rst = 1'b0;

        // continuous stream across the frame wrap
        b2b = 1;
        enable = 1'b1;
        pix_ready = 1'b1;
        wait_pops(40, 2000);
        chk("sof_count", sofs, 2);
        b2b = 0;
        enable = 1'b0;
        wait_idle(200);

        // backpressure: FIFO fills, then one burst per 8 pops
        pix_ready = 1'b0;
        enable = 1'b1;
        b0 = bursts;
        repeat (200) @(posedge clk);
        #1;
        chk("full_bursts", bursts - b0, 4);
        chk("full_cyc", wb.cyc, 0);
        chk("full_valid", pix_valid, 1);
        b0 = bursts;
        pix_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        pix_ready = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("refill_bursts", bursts - b0, 1);
        chk("refill_cyc", wb.cyc, 0);
        enable = 1'b0;
        pix_ready = 1'b1;
        wait_idle(200);

        // enable dropped mid-burst
        enable = 1'b1;
        wait_rise(100);
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        b0 = bursts;
        repeat (40) @(posedge clk);
        #1;
        chk("drop_bursts", bursts - b0, 1);
        chk("drop_cyc", wb.cyc, 0);
        resume_adr = BASE + 32'(4 * m_idx);
        enable = 1'b1;
        wait_rise(100);
        chk("resume_adr", wb.adr, resume_adr);

        // reset during beat 5
        wait_rise(100);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_cyc", wb.cyc, 0);
        chk("mid_rst_stb", wb.stb, 0);
        chk("mid_rst_valid", pix_valid, 0);
        chk("mid_rst_adr", wb.adr, BASE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b0 = sofs;
        wait_rise(100);
        chk("post_rst_adr", wb.adr, BASE);
        wait_pops(pops + 16, 500);
        chk("post_rst_sof", sofs - b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
